wave_capture: RTL and testbench
===============================

Name: wave_capture

Overview:
- Upstream producer for the adjustable wave display: takes the audio sample stream, waits for a positive-going zero crossing, and writes 256 consecutive 8-bit samples into the 512-entry double-buffered display RAM.
- Writes always go to the half the display is NOT reading.
- Flips `read_index` only when the display reports a frame boundary, so the display never shows a half-written buffer.

Parameters:
- SAMPLE_WIDTH, 16: width of the signed two's-complement input sample.
- DECIM_LOG2, 0: use one sample out of every 2^DECIM_LOG2 accepted samples; 0 uses every sample.
- TIMEOUT, 4096: used samples seen in ARMED without a crossing before a forced auto-trigger; 0 disables auto-trigger.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset; reset is asserted when 0.
- new_sample_ready  in  1  one-cycle strobe; new_sample_in is valid in that cycle.
- new_sample_in  in  SAMPLE_WIDTH  signed audio sample.
- wave_display_idle  in  1  high while the display is outside the active picture (frame boundary).
- write_address  out  9  RAM write address, {~read_index, sample_count[7:0]}.
- write_enable  out  1  one-cycle RAM write strobe.
- write_sample  out  8  unsigned offset-binary sample, {~s[MSB], s[MSB-1:MSB-7]}.
- read_index  out  1  buffer half the display reads; feeds the display's read_index.

Behaviour:
- Reset (reset==0, asynchronous):
  - state=ARMED; read_index=0; write_enable=0; write_address=0; write_sample=0.
  - sample_count=0; decim_count=0; timeout_count=0; prev_neg=0.
- Accepted sample: new_sample_ready==1.
- Used sample: an accepted sample with decim_count==0. decim_count increments (mod 2^DECIM_LOG2) on every accepted sample in ARMED/ACTIVE.
- decim_count, prev_neg and timeout_count are all cleared on entry to ARMED.
- All outputs are registered.
- States: ARMED=0, ACTIVE=1, WAIT=2. Unreachable encoding returns to ARMED.
- ARMED, on a used sample:
  - Crossing (prev_neg==1 and s[MSB]==0): go to ACTIVE, sample_count=0, timeout_count=0.
  - Else if TIMEOUT!=0 and timeout_count==TIMEOUT-1: go to ACTIVE (auto-trigger).
  - Else timeout_count++.
  - prev_neg<=s[MSB] on every used sample.
  - The triggering sample itself is not written.
- ACTIVE, on a used sample:
  - Next cycle: write_enable=1 for exactly one cycle, write_address={~read_index, sample_count}, write_sample=converted s.
  - sample_count++.
  - After the write with sample_count==255: go to WAIT; sample_count wraps to 0.
- Write latency: exactly 1 cycle after the used strobe. Back-to-back strobes produce back-to-back writes.
- WAIT:
  - All samples are ignored (no write, no decimation or prev_neg update).
  - When wave_display_idle==1: toggle read_index and go to ARMED.
  - Stays in WAIT indefinitely otherwise.
- Simultaneous events:
  - new_sample_ready with wave_display_idle in WAIT: flip happens, sample discarded.
  - wave_display_idle in ARMED/ACTIVE has no effect.
- read_index changes only on the WAIT→ARMED transition. The half being written is always ~read_index.
- Conversion examples: 16'h8000→8'h00; 16'h0000→8'h80; 16'h7FFF→8'hFF; 16'hFF00→8'h7F.
- Reset mid-ACTIVE: the partial buffer is abandoned, write_enable drops immediately, and read_index returns to 0.

Test Plan:
1. Reset, DECIM_LOG2=0: feed −100, −50, +10 strobes → ACTIVE after +10, no write for it. Next 256 strobes of 16'h1234 → 256 writes to addresses 256..511, write_sample=8'h92, each one cycle after its strobe. Then state WAIT with read_index=0.
2. In WAIT, hold wave_display_idle=0 for 1000 cycles with strobes → no writes, read_index stays 0. Pulse idle one cycle → read_index=1. Next crossing capture writes addresses 0..255.
3. Constant positive samples, TIMEOUT=8 → no crossing; auto-trigger after the 8th used sample. Writes begin on the 9th strobe.
4. DECIM_LOG2=2: strobe a ramp 0,1,2,… after a trigger → written samples come from every 4th strobe only; 256 writes span 1024 strobes.
5. Assert reset low asynchronously mid-ACTIVE at sample_count=100 → write_enable=0 immediately, read_index=0. After release, the capture restarts from ARMED and needs a fresh crossing.
6. Same-cycle new_sample_ready and wave_display_idle in WAIT → read_index toggles and no write occurs. Following −1, +1 strobes retrigger.

Source files
------------

// File: rtl/wave_capture.sv
// Captures 256 samples after a positive-going zero crossing into the half of the
// double-buffered wave RAM the display is not reading; flips halves at frame boundaries.
module wave_capture #(
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned DECIM_LOG2   = 0,
  parameter int unsigned TIMEOUT      = 4096
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    new_sample_ready,
  input  logic [SAMPLE_WIDTH-1:0] new_sample_in,
  input  logic                    wave_display_idle,
  output logic [8:0]              write_address,
  output logic                    write_enable,
  output logic [7:0]              write_sample,
  output logic                    read_index
);

  localparam int unsigned DW    = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam int unsigned TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned TLAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {
    ARMED  = 2'd0,
    ACTIVE = 2'd1,
    WAIT   = 2'd2
  } state_e;

  state_e          state_q;
  logic [7:0]      sample_count_q;
  logic [DW-1:0]   decim_count_q;
  logic [TW-1:0]   timeout_count_q;
  logic            prev_neg_q;
  logic            read_index_q;
  logic            write_enable_q;
  logic [8:0]      write_address_q;
  logic [7:0]      write_sample_q;

  logic            sample_neg;
  logic            used;
  logic            crossing;
  logic [7:0]      sample_conv;
  logic [DW-1:0]   decim_next;

  assign sample_neg  = new_sample_in[SAMPLE_WIDTH-1];
  assign used        = new_sample_ready && (decim_count_q == '0);
  assign crossing    = prev_neg_q && !sample_neg;
  // Offset-binary: flip the sign bit, keep the next 7 magnitude bits.
  assign sample_conv = {~sample_neg, new_sample_in[SAMPLE_WIDTH-2 -: 7]};
  assign decim_next  = (DECIM_LOG2 == 0) ? '0 : DW'(decim_count_q + DW'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= ARMED;
      sample_count_q  <= '0;
      decim_count_q   <= '0;
      timeout_count_q <= '0;
      prev_neg_q      <= 1'b0;
      read_index_q    <= 1'b0;
      write_enable_q  <= 1'b0;
      write_address_q <= '0;
      write_sample_q  <= '0;
    end else begin
      write_enable_q <= 1'b0;
      case (state_q)
        ARMED: begin
          if (new_sample_ready) begin
            decim_count_q <= decim_next;
          end
          if (used) begin
            prev_neg_q <= sample_neg;
            if (crossing || (TIMEOUT != 0 && timeout_count_q == TW'(TLAST))) begin
              state_q         <= ACTIVE;
              sample_count_q  <= '0;
              timeout_count_q <= '0;
            end else if (TIMEOUT != 0) begin
              timeout_count_q <= TW'(timeout_count_q + TW'(1));
            end
          end
        end
        ACTIVE: begin
          if (new_sample_ready) begin
            decim_count_q <= decim_next;
          end
          if (used) begin
            write_enable_q  <= 1'b1;
            write_address_q <= {~read_index_q, sample_count_q};
            write_sample_q  <= sample_conv;
            sample_count_q  <= sample_count_q + 8'd1;
            if (sample_count_q == 8'hFF) begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          // Flip only at a frame boundary so the display never sees a partial buffer.
          if (wave_display_idle) begin
            read_index_q    <= ~read_index_q;
            state_q         <= ARMED;
            decim_count_q   <= '0;
            timeout_count_q <= '0;
            prev_neg_q      <= 1'b0;
          end
        end
        default: begin
          state_q         <= ARMED;
          decim_count_q   <= '0;
          timeout_count_q <= '0;
          prev_neg_q      <= 1'b0;
        end
      endcase
    end
  end

  assign write_address = write_address_q;
  assign write_enable  = write_enable_q;
  assign write_sample  = write_sample_q;
  assign read_index    = read_index_q;

endmodule

// File: tb/tb_wave_capture.sv
// Bench for wave_capture: three instances (default, short timeout, decimate-by-4)
// checked each cycle against a sample-level model, plus directed literal checks.
module tb_wave_capture;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        rdy  [3];
  logic [15:0] smp  [3];
  logic        idle [3];
  logic [8:0]  wa   [3];
  logic        we   [3];
  logic [7:0]  ws   [3];
  logic        ri   [3];

  always #5 clk = ~clk;

  wave_capture #(.SAMPLE_WIDTH(16), .DECIM_LOG2(0), .TIMEOUT(4096)) u_dut0 (
    .clk(clk), .reset(rst_n), .new_sample_ready(rdy[0]), .new_sample_in(smp[0]),
    .wave_display_idle(idle[0]), .write_address(wa[0]), .write_enable(we[0]),
    .write_sample(ws[0]), .read_index(ri[0]));

  wave_capture #(.SAMPLE_WIDTH(16), .DECIM_LOG2(0), .TIMEOUT(8)) u_dut1 (
    .clk(clk), .reset(rst_n), .new_sample_ready(rdy[1]), .new_sample_in(smp[1]),
    .wave_display_idle(idle[1]), .write_address(wa[1]), .write_enable(we[1]),
    .write_sample(ws[1]), .read_index(ri[1]));

  wave_capture #(.SAMPLE_WIDTH(16), .DECIM_LOG2(2), .TIMEOUT(4096)) u_dut2 (
    .clk(clk), .reset(rst_n), .new_sample_ready(rdy[2]), .new_sample_in(smp[2]),
    .wave_display_idle(idle[2]), .write_address(wa[2]), .write_enable(we[2]),
    .write_sample(ws[2]), .read_index(ri[2]));

  function automatic int decim_of(input int i);
    return (i == 2) ? 4 : 1;
  endfunction

  function automatic int timeout_of(input int i);
    return (i == 1) ? 8 : 4096;
  endfunction

  // Model: hunting for a trigger, or filled count of the current buffer (256 = holding).
  bit m_hunt    [3];
  int m_filled  [3];
  int m_acc     [3];
  int m_miss    [3];
  bit m_lastneg [3];
  bit m_page    [3];
  bit e_we      [3];
  int e_wa      [3];
  int e_ws      [3];

  int n_pass  = 0;
  int n_total = 0;
  int w_cnt   [3];
  int last_wa [3];
  int base;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_hunt[i] = 1'b1; m_filled[i] = 0; m_acc[i] = 0; m_miss[i] = 0;
      m_lastneg[i] = 1'b0; m_page[i] = 1'b0;
      e_we[i] = 1'b0; e_wa[i] = 0; e_ws[i] = 0;
    end
  endtask

  task automatic model_step();
    bit used;
    int v;
    for (int i = 0; i < 3; i++) begin
      e_we[i] = 1'b0;
      if (!m_hunt[i] && m_filled[i] == 256) begin
        if (idle[i]) begin
          m_page[i] = ~m_page[i];
          m_hunt[i] = 1'b1; m_filled[i] = 0; m_acc[i] = 0;
          m_miss[i] = 0; m_lastneg[i] = 1'b0;
        end
      end else if (rdy[i]) begin
        used = (m_acc[i] % decim_of(i)) == 0;
        m_acc[i]++;
        v = int'($signed(smp[i]));
        if (used && m_hunt[i]) begin
          if ((m_lastneg[i] && v >= 0) || (m_miss[i] + 1 == timeout_of(i))) begin
            m_hunt[i] = 1'b0;
            m_filled[i] = 0;
          end else begin
            m_miss[i]++;
          end
          m_lastneg[i] = (v < 0);
        end else if (used) begin
          e_we[i] = 1'b1;
          e_wa[i] = (m_page[i] ? 0 : 256) + m_filled[i];
          e_ws[i] = (v + 32768) / 256;
          m_filled[i]++;
        end
      end
    end
  endtask

  task automatic chk(input string nm, input int i, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h at %0t", nm, i, act, exp, $time);
  endtask

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      chk("we", i, int'(we[i]), int'(e_we[i]));
      if (e_we[i]) begin
        chk("waddr", i, int'(wa[i]), e_wa[i]);
        chk("wsample", i, int'(ws[i]), e_ws[i]);
      end
      chk("rindex", i, int'(ri[i]), int'(m_page[i]));
      if (we[i] === 1'b1) begin
        w_cnt[i]++;
        last_wa[i] = int'(wa[i]);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic strobe(input int i, input logic [15:0] v);
    rdy[i] = 1'b1; smp[i] = v;
    tick();
    rdy[i] = 1'b0;
  endtask

  task automatic pulse_idle(input int i);
    idle[i] = 1'b1;
    tick();
    idle[i] = 1'b0;
  endtask

  task automatic reset_all();
    rst_n = 1'b0;
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rdy[i] = 1'b0; smp[i] = '0; idle[i] = 1'b0; w_cnt[i] = 0; last_wa[i] = 0;
    end
    #2;
    reset_all();
    for (int i = 0; i < 3; i++) begin
      chk("rst_we", i, int'(we[i]), 0);
      chk("rst_waddr", i, int'(wa[i]), 0);
      chk("rst_wsample", i, int'(ws[i]), 0);
      chk("rst_rindex", i, int'(ri[i]), 0);
    end

    // Crossing capture into the upper half.
    strobe(0, 16'hFF9C);
    strobe(0, 16'hFFCE);
    strobe(0, 16'h000A);
    chk("t1_trig_nowrite", 0, int'(we[0]), 0);
    base = w_cnt[0];
    strobe(0, 16'h1234);
    chk("t1_first_we", 0, int'(we[0]), 1);
    chk("t1_first_addr", 0, int'(wa[0]), 256);
    chk("t1_first_sample", 0, int'(ws[0]), 8'h92);
    for (int k = 1; k < 256; k++) strobe(0, 16'h1234);
    tick();
    chk("t1_count", 0, w_cnt[0] - base, 256);
    chk("t1_last_addr", 0, last_wa[0], 511);
    chk("t1_rindex", 0, int'(ri[0]), 0);
    strobe(0, 16'h1234);
    chk("t1_wait_nowrite", 0, int'(we[0]), 0);

    // Hold in WAIT, flip, capture into the lower half.
    base = w_cnt[0];
    for (int k = 0; k < 1000; k++) strobe(0, (k % 2 == 1) ? 16'hFFF0 : 16'h0010);
    chk("t2_hold_count", 0, w_cnt[0] - base, 0);
    chk("t2_hold_rindex", 0, int'(ri[0]), 0);
    pulse_idle(0);
    chk("t2_flip", 0, int'(ri[0]), 1);
    strobe(0, 16'hFFFF);
    strobe(0, 16'h0001);
    chk("t2_trig_nowrite", 0, int'(we[0]), 0);
    base = w_cnt[0];
    strobe(0, 16'h8000);
    chk("t2_addr0", 0, int'(wa[0]), 0);
    chk("t2_conv_8000", 0, int'(ws[0]), 8'h00);
    strobe(0, 16'h0000);
    chk("t2_conv_0000", 0, int'(ws[0]), 8'h80);
    strobe(0, 16'hFF00);
    chk("t2_conv_ff00", 0, int'(ws[0]), 8'h7F);
    strobe(0, 16'h7FFF);
    chk("t2_conv_7fff", 0, int'(ws[0]), 8'hFF);
    chk("t2_addr3", 0, int'(wa[0]), 3);
    for (int k = 4; k < 256; k++) strobe(0, 16'(k * 97));
    tick();
    chk("t2_count", 0, w_cnt[0] - base, 256);
    chk("t2_last_addr", 0, last_wa[0], 255);

    // Strobe and frame boundary together in WAIT.
    rdy[0] = 1'b1; smp[0] = 16'h0007; idle[0] = 1'b1;
    tick();
    rdy[0] = 1'b0; idle[0] = 1'b0;
    chk("t6_flip", 0, int'(ri[0]), 0);
    chk("t6_nowrite", 0, int'(we[0]), 0);
    strobe(0, 16'hFFFF);
    strobe(0, 16'h0001);
    base = w_cnt[0];
    strobe(0, 16'h4000);
    chk("t6_we", 0, int'(we[0]), 1);
    chk("t6_addr", 0, int'(wa[0]), 256);
    chk("t6_sample", 0, int'(ws[0]), 8'hC0);
    for (int k = 1; k < 256; k++) strobe(0, 16'h4000);
    tick();
    chk("t6_count", 0, w_cnt[0] - base, 256);
    pulse_idle(0);
    chk("t6_flip2", 0, int'(ri[0]), 1);

    // Asynchronous reset in the middle of a capture.
    strobe(0, 16'hFFFF);
    strobe(0, 16'h0001);
    for (int k = 0; k < 100; k++) strobe(0, 16'h0100);
    chk("t5_pre_we", 0, int'(we[0]), 1);
    chk("t5_pre_addr", 0, int'(wa[0]), 99);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t5_rst_we", 0, int'(we[0]), 0);
    chk("t5_rst_rindex", 0, int'(ri[0]), 0);
    tick();
    rst_n = 1'b1;
    tick();
    base = w_cnt[0];
    for (int k = 0; k < 3; k++) strobe(0, 16'h0005);
    tick();
    chk("t5_no_retrigger", 0, w_cnt[0] - base, 0);
    strobe(0, 16'hFFFF);
    strobe(0, 16'h0001);
    strobe(0, 16'h1234);
    chk("t5_restart_addr", 0, int'(wa[0]), 256);

    // Auto-trigger after 8 used samples without a crossing.
    reset_all();
    base = w_cnt[1];
    for (int k = 0; k < 8; k++) strobe(1, 16'h0064);
    chk("t3_8th_nowrite", 1, int'(we[1]), 0);
    chk("t3_count8", 1, w_cnt[1] - base, 0);
    strobe(1, 16'h0010);
    chk("t3_9th_we", 1, int'(we[1]), 1);
    chk("t3_9th_addr", 1, int'(wa[1]), 256);
    chk("t3_9th_sample", 1, int'(ws[1]), 8'h80);

    // Decimate by 4: every 4th accepted sample is used.
    reset_all();
    strobe(2, 16'hFFF6);
    for (int k = 0; k < 3; k++) strobe(2, 16'h7000);
    strobe(2, 16'h000A);
    chk("t4_trig_nowrite", 2, int'(we[2]), 0);
    base = w_cnt[2];
    for (int k = 0; k < 1024; k++) begin
      strobe(2, 16'(k << 8));
      if (k == 2) chk("t4_skip", 2, int'(we[2]), 0);
      if (k == 3) begin
        chk("t4_first_we", 2, int'(we[2]), 1);
        chk("t4_first_sample", 2, int'(ws[2]), 8'h83);
        chk("t4_first_addr", 2, int'(wa[2]), 256);
      end
      if (k == 7) begin
        chk("t4_second_sample", 2, int'(ws[2]), 8'h87);
        chk("t4_second_addr", 2, int'(wa[2]), 257);
      end
    end
    tick();
    chk("t4_count", 2, w_cnt[2] - base, 256);
    chk("t4_last_addr", 2, last_wa[2], 511);
    chk("t4_rindex", 2, int'(ri[2]), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
